// File: rtl/biquad_notch_mc_if.sv
// Sample-in / result-out handshake bundle for the multichannel notch biquad.
interface biquad_notch_mc_if #(
  parameter int WIDTH = 16,
  parameter int CHW   = 2
);
  logic                    s_valid;
  logic                    s_ready;
  logic        [CHW-1:0]   s_ch;
  logic signed [WIDTH-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic        [CHW-1:0]   m_ch;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_sat;

  modport master (
    output s_valid, s_ch, s_data, m_ready,
    input  s_ready, m_valid, m_ch, m_data, m_sat
  );

  modport slave (
    input  s_valid, s_ch, s_data, m_ready,
    output s_ready, m_valid, m_ch, m_data, m_sat
  );
endinterface

// File: rtl/biquad_notch_mc.sv
// Time-multiplexed direct-form-I biquad: one shared multiplier, five MAC cycles per
// sample, per-channel coefficients and state, rounded and saturated output.
module biquad_notch_mc #(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int CH     = 4,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  biquad_notch_mc_if.slave         bus,
  input  logic                     coef_we,
  input  logic        [CHW-1:0]    coef_ch,
  input  logic        [2:0]        coef_sel,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     busy
);
  localparam int          PW    = WIDTH + COEF_W;
  localparam int          AW    = WIDTH + COEF_W + 3;
  localparam int unsigned NSLOT = 1 << CHW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic signed [COEF_W-1:0] B0_RST = COEF_W'(16384);
  localparam logic signed [COEF_W-1:0] B1_RST = COEF_W'(-26453);
  localparam logic signed [COEF_W-1:0] B2_RST = COEF_W'(16384);
  localparam logic signed [COEF_W-1:0] A1_RST = COEF_W'(-26453);
  localparam logic signed [COEF_W-1:0] A2_RST = COEF_W'(15400);

  localparam logic signed [AW-1:0]    ROUND = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [AW-1:0]    YMAX  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]    YMIN  = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] OMAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OMIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic        [1:0]        r_state;
  logic signed [COEF_W-1:0] r_b0 [NSLOT];
  logic signed [COEF_W-1:0] r_b1 [NSLOT];
  logic signed [COEF_W-1:0] r_b2 [NSLOT];
  logic signed [COEF_W-1:0] r_a1 [NSLOT];
  logic signed [COEF_W-1:0] r_a2 [NSLOT];
  logic                     r_byp[NSLOT];
  logic signed [WIDTH-1:0]  r_x1 [NSLOT];
  logic signed [WIDTH-1:0]  r_x2 [NSLOT];
  logic signed [WIDTH-1:0]  r_y1 [NSLOT];
  logic signed [WIDTH-1:0]  r_y2 [NSLOT];
  logic        [CHW-1:0]    r_ch;
  logic signed [WIDTH-1:0]  r_x;
  logic signed [AW-1:0]     r_acc;
  logic        [2:0]        r_cnt;
  logic                     r_mv;
  logic        [CHW-1:0]    r_mch;
  logic signed [WIDTH-1:0]  r_md;
  logic                     r_msat;

  logic signed [COEF_W-1:0] w_coef;
  logic signed [WIDTH-1:0]  w_opnd;
  logic signed [PW-1:0]     w_prod;
  logic signed [AW-1:0]     w_ext;
  logic signed [AW-1:0]     w_acc_next;
  logic signed [AW-1:0]     w_shf;
  logic signed [WIDTH-1:0]  w_y;
  logic                     w_sat;
  logic                     w_s_ok;
  logic                     w_c_ok;

  assign w_s_ok = 32'(bus.s_ch) < CH;
  assign w_c_ok = 32'(coef_ch) < CH;

  always_comb begin
    w_coef = r_b0[r_ch];
    w_opnd = r_x;
    case (r_cnt)
      3'd1: begin w_coef = r_b1[r_ch]; w_opnd = r_x1[r_ch]; end
      3'd2: begin w_coef = r_b2[r_ch]; w_opnd = r_x2[r_ch]; end
      3'd3: begin w_coef = r_a1[r_ch]; w_opnd = r_y1[r_ch]; end
      3'd4: begin w_coef = r_a2[r_ch]; w_opnd = r_y2[r_ch]; end
      default: ;
    endcase
  end

  // Both operands sign-extended to PW bits, so the truncated product is exact.
  assign w_prod     = {{WIDTH{w_coef[COEF_W-1]}}, w_coef} * {{COEF_W{w_opnd[WIDTH-1]}}, w_opnd};
  assign w_ext      = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_next = (r_cnt >= 3'd3) ? r_acc - w_ext : r_acc + w_ext;
  assign w_shf      = (w_acc_next + ROUND) >>> FRAC;

  always_comb begin
    w_y   = w_shf[WIDTH-1:0];
    w_sat = 1'b0;
    if (r_byp[r_ch]) begin
      w_y = r_x;
    end else if (w_shf > YMAX) begin
      w_y   = OMAX;
      w_sat = 1'b1;
    end else if (w_shf < YMIN) begin
      w_y   = OMIN;
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_x     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_mv    <= 1'b0;
      r_mch   <= '0;
      r_md    <= '0;
      r_msat  <= 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        r_b0[i]  <= B0_RST;
        r_b1[i]  <= B1_RST;
        r_b2[i]  <= B2_RST;
        r_a1[i]  <= A1_RST;
        r_a2[i]  <= A2_RST;
        r_byp[i] <= 1'b0;
        r_x1[i]  <= '0;
        r_x2[i]  <= '0;
        r_y1[i]  <= '0;
        r_y2[i]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          // Writes land at this edge; a coincident sample reads them from MAC onward.
          if (coef_we && w_c_ok) begin
            case (coef_sel)
              3'd0: r_b0[coef_ch]  <= coef_data;
              3'd1: r_b1[coef_ch]  <= coef_data;
              3'd2: r_b2[coef_ch]  <= coef_data;
              3'd3: r_a1[coef_ch]  <= coef_data;
              3'd4: r_a2[coef_ch]  <= coef_data;
              3'd5: r_byp[coef_ch] <= coef_data[0];
              3'd6: begin
                r_x1[coef_ch] <= '0;
                r_x2[coef_ch] <= '0;
                r_y1[coef_ch] <= '0;
                r_y2[coef_ch] <= '0;
              end
              default: ;
            endcase
          end
          if (bus.s_valid && w_s_ok) begin
            r_ch    <= bus.s_ch;
            r_x     <= bus.s_data;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd4) begin
            r_x2[r_ch] <= r_x1[r_ch];
            r_x1[r_ch] <= r_x;
            r_y2[r_ch] <= r_y1[r_ch];
            r_y1[r_ch] <= w_y;
            r_md       <= w_y;
            r_msat     <= w_sat;
            r_mch      <= r_ch;
            r_mv       <= 1'b1;
            r_state    <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            r_mv    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = (r_state == IDLE);
  assign bus.m_valid = r_mv;
  assign bus.m_ch    = r_mch;
  assign bus.m_data  = r_md;
  assign bus.m_sat   = r_msat;
  assign busy        = (r_state != IDLE);
endmodule
